// File: rtl/window_pad_unit_if.sv
// Window stream interfaces for the 3x3 border-padding stage.
// The input side carries a raw window and frame-start flag; the output side adds centre position and end-of-frame.
interface window_pad_in_if #(
    parameter int unsigned WIN_W = 72
) ();
    logic             valid;
    logic             ready;
    logic             sof;
    logic [WIN_W-1:0] win;

    modport master (output valid, sof, win, input ready);
    modport slave  (input valid, sof, win, output ready);
endinterface

interface window_pad_out_if #(
    parameter int unsigned WIN_W = 72,
    parameter int unsigned RW    = 10,
    parameter int unsigned CW    = 10
) ();
    logic             valid;
    logic             ready;
    logic [WIN_W-1:0] win;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    logic             eof;

    modport master (output valid, win, row, col, eof, input ready);
    modport slave  (input valid, win, row, col, eof, output ready);
endinterface

// File: rtl/window_pad_unit.sv
// 3x3 window border-padding stage: tracks the window centre position per frame and
// replaces out-of-image taps with zero, replicated edge samples or a constant.
module window_pad_unit #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CH    = 1,
    parameter int unsigned MAX_W = 640,
    parameter int unsigned MAX_H = 640,
    localparam int unsigned TW    = CH * DW,
    localparam int unsigned WIN_W = 9 * TW,
    localparam int unsigned CW    = $clog2(MAX_W),
    localparam int unsigned RW    = $clog2(MAX_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    cfg_width_i,
    input  logic [RW-1:0]    cfg_height_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic [TW-1:0]    cfg_pad_i,
    window_pad_in_if.slave   in_if,
    window_pad_out_if.master out_if
);

    localparam logic [1:0] MODE_REPL  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    logic             in_ready_c;
    logic             accept_c;

    logic [CW-1:0]    act_w_q, act_w_d;
    logic [RW-1:0]    act_h_q, act_h_d;
    logic [1:0]       act_mode_q, act_mode_d;
    logic [TW-1:0]    act_pad_q, act_pad_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;

    logic             out_valid_q, out_valid_d;
    logic [WIN_W-1:0] out_win_q, out_win_d;
    logic [RW-1:0]    out_row_q, out_row_d;
    logic [CW-1:0]    out_col_q, out_col_d;
    logic             out_eof_q, out_eof_d;

    logic [CW-1:0]    eff_w, eff_col;
    logic [RW-1:0]    eff_h, eff_row;
    logic [1:0]       eff_mode;
    logic [TW-1:0]    eff_pad;
    logic             pad_top, pad_bot, pad_left, pad_right;

    logic [TW-1:0]    tap_in   [9];
    logic [TW-1:0]    tap_v    [9];
    logic [TW-1:0]    tap_rep  [9];
    logic [TW-1:0]    tap_fill [9];
    logic [WIN_W-1:0] pad_win;

    assign in_ready_c = ~out_valid_q | out_if.ready;
    assign accept_c   = in_if.valid & in_ready_c;
    assign in_if.ready = in_ready_c;

    assign out_if.valid = out_valid_q;
    assign out_if.win   = out_win_q;
    assign out_if.row   = out_row_q;
    assign out_if.col   = out_col_q;
    assign out_if.eof   = out_eof_q;

    // A frame-start beat is processed as (0,0) with the live cfg, not the active copy
    always_comb begin
        eff_w     = in_if.sof ? cfg_width_i  : act_w_q;
        eff_h     = in_if.sof ? cfg_height_i : act_h_q;
        eff_mode  = in_if.sof ? cfg_mode_i   : act_mode_q;
        eff_pad   = in_if.sof ? cfg_pad_i    : act_pad_q;
        eff_row   = in_if.sof ? '0 : row_q;
        eff_col   = in_if.sof ? '0 : col_q;
        pad_top   = (eff_row == '0);
        pad_bot   = (eff_row == eff_h - RW'(1));
        pad_left  = (eff_col == '0);
        pad_right = (eff_col == eff_w - CW'(1));
    end

    // Replicate is vertical first, then horizontal on the result so corners take the centre-adjacent value
    always_comb begin
        for (int t = 0; t < 9; t++) begin
            tap_in[t] = in_if.win[(8 - t) * TW +: TW];
            tap_v[t]  = tap_in[t];
        end
        for (int c = 0; c < 3; c++) begin
            if (pad_top) tap_v[c]     = tap_in[3 + c];
            if (pad_bot) tap_v[6 + c] = tap_in[3 + c];
        end
        for (int r = 0; r < 3; r++) begin
            tap_rep[3 * r]     = pad_left  ? tap_v[3 * r + 1] : tap_v[3 * r];
            tap_rep[3 * r + 1] = tap_v[3 * r + 1];
            tap_rep[3 * r + 2] = pad_right ? tap_v[3 * r + 1] : tap_v[3 * r + 2];
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ((r == 0 && pad_top) || (r == 2 && pad_bot) ||
                    (c == 0 && pad_left) || (c == 2 && pad_right)) begin
                    tap_fill[3 * r + c] = (eff_mode == MODE_CONST) ? eff_pad : '0;
                end else begin
                    tap_fill[3 * r + c] = tap_in[3 * r + c];
                end
            end
        end
        pad_win = '0;
        for (int t = 0; t < 9; t++) begin
            pad_win[(8 - t) * TW +: TW] = (eff_mode == MODE_REPL) ? tap_rep[t] : tap_fill[t];
        end
    end

    // Output register, position counters and active cfg copy
    always_comb begin
        act_w_d     = act_w_q;
        act_h_d     = act_h_q;
        act_mode_d  = act_mode_q;
        act_pad_d   = act_pad_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q & ~out_if.ready;
        out_win_d   = out_win_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_eof_d   = out_eof_q;

        if (accept_c) begin
            out_valid_d = 1'b1;
            out_win_d   = pad_win;
            out_row_d   = eff_row;
            out_col_d   = eff_col;
            out_eof_d   = pad_bot & pad_right;

            if (in_if.sof) begin
                act_w_d    = cfg_width_i;
                act_h_d    = cfg_height_i;
                act_mode_d = cfg_mode_i;
                act_pad_d  = cfg_pad_i;
            end

            if (pad_right) begin
                col_d = '0;
                if (pad_bot) begin
                    row_d      = '0;
                    act_w_d    = cfg_width_i;
                    act_h_d    = cfg_height_i;
                    act_mode_d = cfg_mode_i;
                    act_pad_d  = cfg_pad_i;
                end else begin
                    row_d = eff_row + RW'(1);
                end
            end else begin
                row_d = eff_row;
                col_d = eff_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_w_q     <= cfg_width_i;
            act_h_q     <= cfg_height_i;
            act_mode_q  <= cfg_mode_i;
            act_pad_q   <= cfg_pad_i;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_win_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_eof_q   <= 1'b0;
        end else begin
            act_w_q     <= act_w_d;
            act_h_q     <= act_h_d;
            act_mode_q  <= act_mode_d;
            act_pad_q   <= act_pad_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_win_q   <= out_win_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_eof_q   <= out_eof_d;
        end
    end

endmodule

// File: tb/tb_window_pad_unit.sv
// Bench for window_pad_unit: hand-computed vector table plus a scoreboarded stream
// covering back-pressure, mid-frame resync, 1x1 images and mid-frame reset.
module tb_window_pad_unit;

    localparam int unsigned DW    = 8;
    localparam int unsigned CH    = 1;
    localparam int unsigned TW    = CH * DW;
    localparam int unsigned WIN_W = 9 * TW;
    localparam int unsigned CW    = 10;
    localparam int unsigned RW    = 10;

    logic          clk;
    logic          rst;
    logic [CW-1:0] cfg_width;
    logic [RW-1:0] cfg_height;
    logic [1:0]    cfg_mode;
    logic [TW-1:0] cfg_pad;

    window_pad_in_if  #(.WIN_W(WIN_W))                   in_if ();
    window_pad_out_if #(.WIN_W(WIN_W), .RW(RW), .CW(CW)) out_if ();

    window_pad_unit #(.DW(DW), .CH(CH), .MAX_W(640), .MAX_H(640)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_width_i  (cfg_width),
        .cfg_height_i (cfg_height),
        .cfg_mode_i   (cfg_mode),
        .cfg_pad_i    (cfg_pad),
        .in_if        (in_if),
        .out_if       (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIN_W-1:0] win;
        logic [RW-1:0]    row;
        logic [CW-1:0]    col;
        logic             eof;
    } exp_t;

    typedef struct {
        logic [1:0]       mode;
        logic [TW-1:0]    pad;
        logic [CW-1:0]    w;
        logic [RW-1:0]    h;
        int               tr;
        int               tc;
        logic [WIN_W-1:0] exp_win;
    } vec_t;

    exp_t          sb_q[$];
    vec_t          vt[12];
    int            n_checks = 0;
    int            n_fail   = 0;

    // Bench-side frame tracker
    logic [CW-1:0] m_w;
    logic [RW-1:0] m_h;
    logic [1:0]    m_mode;
    logic [TW-1:0] m_pad;
    logic [RW-1:0] m_row;
    logic [CW-1:0] m_col;

    task automatic chk(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [TW-1:0] tap_of(input logic [WIN_W-1:0] w, input int t);
        return w[(8 - t) * TW +: TW];
    endfunction

    function automatic logic [WIN_W-1:0] model_pad(input logic [WIN_W-1:0] win,
                                                   input logic [RW-1:0] row, input logic [CW-1:0] col,
                                                   input logic [CW-1:0] w, input logic [RW-1:0] h,
                                                   input logic [1:0] mode, input logic [TW-1:0] pad);
        logic [WIN_W-1:0] res;
        logic [TW-1:0]    v;
        bit               pr, pc;
        res = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pr = (r == 0 && row == '0) || (r == 2 && row == h - RW'(1));
                pc = (c == 0 && col == '0) || (c == 2 && col == w - CW'(1));
                if (!pr && !pc)        v = tap_of(win, 3 * r + c);
                else if (mode == 2'd1) v = tap_of(win, (pr ? 1 : r) * 3 + (pc ? 1 : c));
                else if (mode == 2'd2) v = pad;
                else                   v = '0;
                res[(8 - (3 * r + c)) * TW +: TW] = v;
            end
        end
        return res;
    endfunction

    task automatic load_active();
        m_w    = cfg_width;
        m_h    = cfg_height;
        m_mode = cfg_mode;
        m_pad  = cfg_pad;
    endtask

    // Push the expected output, then offer the beat until accepted (bounded)
    task automatic drive_beat(input logic [WIN_W-1:0] win, input logic sof,
                              input bit ovr, input logic [WIN_W-1:0] ovr_win);
        exp_t e;
        int   n;
        bit   rdy;
        bit   last_c, last_r;
        if (sof) begin
            load_active();
            m_row = '0;
            m_col = '0;
        end
        last_c = (m_col == m_w - CW'(1));
        last_r = (m_row == m_h - RW'(1));
        e.row  = m_row;
        e.col  = m_col;
        e.eof  = last_c && last_r;
        e.win  = ovr ? ovr_win : model_pad(win, m_row, m_col, m_w, m_h, m_mode, m_pad);
        sb_q.push_back(e);
        if (last_c) begin
            m_col = '0;
            if (last_r) begin
                m_row = '0;
                load_active();
            end else begin
                m_row = m_row + RW'(1);
            end
        end else begin
            m_col = m_col + CW'(1);
        end
        in_if.valid = 1'b1;
        in_if.sof   = sof;
        in_if.win   = win;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = in_if.ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_if.valid = 1'b0;
        in_if.sof   = 1'b0;
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", n);
        end
    endtask

    // Hold out_ready low for 5 cycles and require the output register to stay put
    task automatic stall_seq();
        logic [WIN_W-1:0] w0;
        logic [RW-1:0]    r0;
        logic [CW-1:0]    c0;
        out_if.ready = 1'b0;
        @(negedge clk);
        w0 = out_if.win;
        r0 = out_if.row;
        c0 = out_if.col;
        chk("stall_row", WIN_W'(r0), WIN_W'(1));
        chk("stall_col", WIN_W'(c0), WIN_W'(1));
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_in_ready",  WIN_W'(in_if.ready),  WIN_W'(0));
            chk("stall_out_valid", WIN_W'(out_if.valid), WIN_W'(1));
            chk("stall_win_hold",  out_if.win, w0);
            chk("stall_row_hold",  WIN_W'(out_if.row), WIN_W'(r0));
            chk("stall_col_hold",  WIN_W'(out_if.col), WIN_W'(c0));
        end
        @(posedge clk);
        #1;
        out_if.ready = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_if.valid && out_if.ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got row %0d col %0d, expected none", out_if.row, out_if.col);
            end else begin
                e = sb_q.pop_front();
                chk("out_win", out_if.win, e.win);
                chk("out_row", WIN_W'(out_if.row), WIN_W'(e.row));
                chk("out_col", WIN_W'(out_if.col), WIN_W'(e.col));
                chk("out_eof", WIN_W'(out_if.eof), WIN_W'(e.eof));
            end
        end
    end

    initial begin
        logic [WIN_W-1:0] base;
        logic [WIN_W-1:0] w;
        int               tgt;
        int               n;

        base = 72'h11_22_33_44_55_66_77_88_99;
        vt[0]  = '{2'd0, 8'h00, 10'd4, 10'd3, 0, 0, 72'h00_00_00_00_55_66_00_88_99};
        vt[1]  = '{2'd0, 8'h00, 10'd4, 10'd3, 1, 1, 72'h11_22_33_44_55_66_77_88_99};
        vt[2]  = '{2'd0, 8'h00, 10'd4, 10'd3, 2, 3, 72'h11_22_00_44_55_00_00_00_00};
        vt[3]  = '{2'd1, 8'h00, 10'd4, 10'd3, 0, 0, 72'h55_55_66_55_55_66_88_88_99};
        vt[4]  = '{2'd1, 8'h00, 10'd4, 10'd3, 2, 3, 72'h11_22_22_44_55_55_44_55_55};
        vt[5]  = '{2'd2, 8'h7F, 10'd4, 10'd3, 0, 3, 72'h7F_7F_7F_44_55_7F_77_88_7F};
        vt[6]  = '{2'd3, 8'h7F, 10'd4, 10'd3, 0, 0, 72'h00_00_00_00_55_66_00_88_99};
        vt[7]  = '{2'd1, 8'h00, 10'd4, 10'd3, 1, 0, 72'h22_22_33_55_55_66_88_88_99};
        vt[8]  = '{2'd0, 8'h00, 10'd1, 10'd1, 0, 0, 72'h00_00_00_00_55_00_00_00_00};
        vt[9]  = '{2'd2, 8'hA5, 10'd1, 10'd1, 0, 0, 72'hA5_A5_A5_A5_55_A5_A5_A5_A5};
        vt[10] = '{2'd1, 8'h00, 10'd4, 10'd3, 1, 3, 72'h11_22_22_44_55_55_77_88_88};
        vt[11] = '{2'd2, 8'h7F, 10'd4, 10'd3, 2, 0, 72'h7F_22_33_7F_55_66_7F_7F_7F};

        rst          = 1'b1;
        cfg_width    = 10'd4;
        cfg_height   = 10'd3;
        cfg_mode     = 2'd0;
        cfg_pad      = 8'h00;
        in_if.valid  = 1'b0;
        in_if.sof    = 1'b0;
        in_if.win    = '0;
        out_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", WIN_W'(out_if.valid), WIN_W'(0));
        chk("reset_out_win",   out_if.win, '0);
        chk("reset_out_row",   WIN_W'(out_if.row), WIN_W'(0));
        chk("reset_out_col",   WIN_W'(out_if.col), WIN_W'(0));
        chk("reset_out_eof",   WIN_W'(out_if.eof), WIN_W'(0));
        chk("reset_in_ready",  WIN_W'(in_if.ready), WIN_W'(1));
        load_active();
        m_row = '0;
        m_col = '0;
        rst   = 1'b0;

        // Hand-computed windows: resync with sof, then step to the target position
        for (int i = 0; i < 12; i++) begin
            cfg_mode   = vt[i].mode;
            cfg_pad    = vt[i].pad;
            cfg_width  = vt[i].w;
            cfg_height = vt[i].h;
            tgt = vt[i].tr * int'(vt[i].w) + vt[i].tc;
            for (int b = 0; b <= tgt; b++) begin
                drive_beat(base, b == 0, b == tgt, vt[i].exp_win);
            end
        end

        // Full W4xH3 frame of random windows; mid-frame cfg change, stall at beat 6
        cfg_width  = 10'd4;
        cfg_height = 10'd3;
        cfg_mode   = 2'd0;
        cfg_pad    = 8'h3C;
        for (int b = 1; b <= 12; b++) begin
            w = WIN_W'({$urandom(), $urandom(), $urandom()});
            if (b == 4) cfg_mode = 2'd1;
            if (b == 7) begin
                fork
                    drive_beat(w, 1'b0, 1'b0, '0);
                    stall_seq();
                join
            end else begin
                drive_beat(w, b == 1, 1'b0, '0);
            end
        end

        // Next frame runs in mode 1 without sof; beat 7 resyncs to (0,0)
        for (int b = 1; b <= 9; b++) begin
            w = WIN_W'({$urandom(), $urandom(), $urandom()});
            if (b == 7) drive_beat(base, 1'b1, 1'b1, 72'h55_55_66_55_55_66_88_88_99);
            else        drive_beat(w, 1'b0, 1'b0, '0);
        end

        // 1x1 image, replicate: every tap equals the centre, eof every beat
        cfg_width  = 10'd1;
        cfg_height = 10'd1;
        cfg_mode   = 2'd1;
        for (int b = 0; b < 4; b++) begin
            w = WIN_W'({$urandom(), $urandom(), $urandom()});
            w[39:32] = 8'h55;
            drive_beat(w, b == 0, 1'b1, {9{8'h55}});
        end

        // Reset mid-frame while an output is pending
        cfg_width  = 10'd4;
        cfg_height = 10'd3;
        cfg_mode   = 2'd0;
        drive_beat(base, 1'b1, 1'b0, '0);
        drive_beat(base, 1'b0, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", WIN_W'(out_if.valid), WIN_W'(0));
        chk("midrst_out_win",   out_if.win, '0);
        chk("midrst_out_row",   WIN_W'(out_if.row), WIN_W'(0));
        chk("midrst_out_col",   WIN_W'(out_if.col), WIN_W'(0));
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        rst = 1'b0;
        load_active();
        m_row = '0;
        m_col = '0;
        for (int b = 0; b < 3; b++) begin
            w = WIN_W'({$urandom(), $urandom(), $urandom()});
            drive_beat(w, 1'b0, 1'b0, '0);
        end

        n = 0;
        while (sb_q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d outputs outstanding, expected 0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        chk("idle_out_valid", WIN_W'(out_if.valid), WIN_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
